// File: rtl/forthsuper_pkg.sv
// Shared types and ASCII constants for the Forth number formatting blocks.
package forthsuper_pkg;

  typedef enum logic [2:0] {IT0, DIV, SGN, EMT, SPC, FIN} itoa_sts;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_A_LC  = 8'h61;
  localparam logic [7:0] CH_MINUS = 8'h2d;
  localparam logic [7:0] CH_SPACE = 8'h20;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return (d < 4'd10) ? (CH_0 + {4'd0, d}) : (CH_A_LC + {4'd0, d} - 8'd10);
  endfunction

endpackage

// File: rtl/udiv10.sv
// Sequential restoring divide-by-10; quotient and remainder valid when done pulses,
// DSZ cycles after start.
module udiv10 #(
  parameter int DSZ = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [DSZ-1:0] dividend,
  output logic [3:0]     rem,
  output logic [DSZ-1:0] quo,
  output logic           done
);
  localparam int CW = $clog2(DSZ);

  logic [DSZ-1:0] q_q, q_d, src;
  logic [3:0]     r_q, r_d, rin;
  logic [4:0]     trial;
  logic           ge;
  logic [CW-1:0]  cnt_q;
  logic           act_q, done_q;

  // The start cycle already performs the first bit step, so only DSZ-1 follow.
  always_comb begin
    src   = start ? dividend : q_q;
    rin   = start ? 4'd0 : r_q;
    trial = {rin, src[DSZ-1]};
    ge    = (trial >= 5'd10);
    r_d   = ge ? 4'(trial - 5'd10) : trial[3:0];
    q_d   = {src[DSZ-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_q  <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        act_q <= 1'b1;
        cnt_q <= CW'(DSZ - 1);
      end else if (act_q) begin
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          act_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start || act_q) begin
      q_q <= q_d;
      r_q <= r_d;
    end
  end

  assign rem  = r_q;
  assign quo  = q_q;
  assign done = done_q;

endmodule

// File: rtl/itoa.sv
// Integer-to-ASCII bus writer: signed decimal or lowercase hex, one byte per cycle.
// Define ITOA_SPACE_EN to append a trailing space after the digits.
module itoa
  import forthsuper_pkg::*;
#(
  parameter int ASZ = 17,
  parameter int DSZ = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           hex,
  input  logic [DSZ-1:0] vi,
  input  logic [ASZ-1:0] tib,
  output logic           bsy,
  output logic           we,
  output logic [ASZ-1:0] ma,
  output logic [7:0]     mo,
  output logic [7:0]     len,
  output logic           done
);
  localparam int DMAX = DSZ * 3 / 10 + 1;
  localparam int SPW  = $clog2(DMAX + 1);

  itoa_sts        st_q, st_d;
  logic           neg_q, neg_d, hex_q, hex_d;
  logic [DSZ-1:0] mag_q, mag_d, mag_shr;
  logic [ASZ-1:0] ma_q, ma_d;
  logic [7:0]     mo_q, mo_d, len_q, len_d;
  logic           we_q, we_d, bsy_q, bsy_d, done_q, done_d;
  logic           dbusy_q, dbusy_d;
  logic [SPW-1:0] sp_q, sp_d, sp_top;
  logic [3:0]     stk_q [DMAX];
  logic           push;
  logic [3:0]     push_val, top_dig;

  logic           div_start, div_done;
  logic [3:0]     div_rem;
  logic [DSZ-1:0] div_quo;

  udiv10 #(.DSZ(DSZ)) u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (div_start),
    .dividend(mag_q),
    .rem     (div_rem),
    .quo     (div_quo),
    .done    (div_done)
  );

  assign sp_top  = (sp_q == '0) ? '0 : sp_q - 1'b1;
  assign top_dig = stk_q[sp_top];
  assign mag_shr = mag_q >> 4;

  always_comb begin
    st_d      = st_q;
    neg_d     = neg_q;
    hex_d     = hex_q;
    mag_d     = mag_q;
    ma_d      = ma_q + {{(ASZ-1){1'b0}}, we_q};
    len_d     = len_q + {7'd0, we_q};
    mo_d      = mo_q;
    we_d      = 1'b0;
    bsy_d     = bsy_q;
    done_d    = 1'b0;
    dbusy_d   = dbusy_q;
    sp_d      = sp_q;
    push      = 1'b0;
    push_val  = 4'd0;
    div_start = 1'b0;
    case (st_q)
      IT0: begin
        if (en) begin
          st_d    = DIV;
          neg_d   = ~hex & vi[DSZ-1];
          hex_d   = hex;
          mag_d   = (~hex & vi[DSZ-1]) ? -vi : vi;
          ma_d    = tib;
          len_d   = 8'd0;
          bsy_d   = 1'b1;
          sp_d    = '0;
          dbusy_d = 1'b0;
        end
      end
      DIV: begin
        if (hex_q) begin
          push     = 1'b1;
          push_val = mag_q[3:0];
          mag_d    = mag_shr;
          if (mag_shr == '0) begin
            st_d = SGN;
            we_d = neg_q;
            mo_d = CH_MINUS;
          end
        end else if (!dbusy_q) begin
          div_start = 1'b1;
          dbusy_d   = 1'b1;
        end else if (div_done) begin
          push     = 1'b1;
          push_val = div_rem;
          mag_d    = div_quo;
          dbusy_d  = 1'b0;
          if (div_quo == '0) begin
            st_d = SGN;
            we_d = neg_q;
            mo_d = CH_MINUS;
          end
        end
        if (push) sp_d = sp_q + 1'b1;
      end
      SGN: begin
        st_d = EMT;
        we_d = 1'b1;
        mo_d = digit_char(top_dig);
        sp_d = sp_q - 1'b1;
      end
      EMT: begin
        if (sp_q != '0) begin
          we_d = 1'b1;
          mo_d = digit_char(top_dig);
          sp_d = sp_q - 1'b1;
        end else begin
`ifdef ITOA_SPACE_EN
          st_d = SPC;
          we_d = 1'b1;
          mo_d = CH_SPACE;
`else
          st_d   = FIN;
          done_d = 1'b1;
          bsy_d  = 1'b0;
`endif
        end
      end
`ifdef ITOA_SPACE_EN
      SPC: begin
        st_d   = FIN;
        done_d = 1'b1;
        bsy_d  = 1'b0;
      end
`endif
      FIN:     st_d = IT0;
      default: st_d = IT0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= IT0;
      bsy_q   <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      ma_q    <= '0;
      mo_q    <= '0;
      len_q   <= '0;
      sp_q    <= '0;
      dbusy_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      bsy_q   <= bsy_d;
      we_q    <= we_d;
      done_q  <= done_d;
      ma_q    <= ma_d;
      mo_q    <= mo_d;
      len_q   <= len_d;
      sp_q    <= sp_d;
      dbusy_q <= dbusy_d;
    end
  end

  always_ff @(posedge clk) begin
    neg_q <= neg_d;
    hex_q <= hex_d;
    mag_q <= mag_d;
    if (push) stk_q[sp_q] <= push_val;
  end

  assign bsy  = bsy_q;
  assign we   = we_q;
  assign ma   = ma_q;
  assign mo   = mo_q;
  assign len  = len_q;
  assign done = done_q;

endmodule

// File: tb/tb_itoa.sv
// Self-checking bench for itoa: directed and random conversions against a string-based model.
module tb_itoa;
  localparam int ASZ = 17;
  localparam int DSZ = 32;
`ifdef ITOA_SPACE_EN
  localparam int SP = 1;
`else
  localparam int SP = 0;
`endif

  logic           clk = 1'b0;
  logic           rst, en, hex;
  logic [DSZ-1:0] vi;
  logic [ASZ-1:0] tib;
  logic           bsy, we, done;
  logic [ASZ-1:0] ma;
  logic [7:0]     mo, len;

  int checks = 0;
  int errors = 0;

  logic [7:0]     exp_q[$];
  logic [7:0]     wd_q[$];
  logic [ASZ-1:0] wa_q[$];

  itoa #(.ASZ(ASZ), .DSZ(DSZ)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .hex (hex),
    .vi  (vi),
    .tib (tib),
    .bsy (bsy),
    .we  (we),
    .ma  (ma),
    .mo  (mo),
    .len (len),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference text from plain formatted printing of the value.
  task automatic model(input bit h, input logic [DSZ-1:0] v, output int ndig);
    string s;
    if (h) s = $sformatf("%0h", v);
    else   s = $sformatf("%0d", $signed(v));
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
    ndig = s.len();
    if (!h && v[DSZ-1]) ndig = ndig - 1;
    if (SP != 0) exp_q.push_back(8'h20);
  endtask

  task automatic run(input string tag, input bit h, input logic [DSZ-1:0] v,
                     input logic [ASZ-1:0] t, input bit poke);
    int ndig, exp_cyc, done_cyc, n;
    bit bsy_bad;
    model(h, v, ndig);
    exp_cyc  = (h ? ndig : ndig * (DSZ + 1)) + 1 + ndig + SP + 1;
    done_cyc = 0;
    bsy_bad  = 1'b0;
    wd_q.delete();
    wa_q.delete();
    @(negedge clk);
    en = 1'b1; hex = h; vi = v; tib = t;
    for (int cyc = 1; cyc <= 500; cyc++) begin
      @(negedge clk);
      if (cyc == 1) en = 1'b0;
      if (poke && cyc == 3) begin
        en = 1'b1; hex = ~h; vi = $urandom; tib = ASZ'($urandom);
      end
      if (poke && cyc == 4) en = 1'b0;
      if (we) begin
        wa_q.push_back(ma);
        wd_q.push_back(mo);
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (bsy !== 1'b1) bsy_bad = 1'b1;
    end
    chk({tag, ".done_cycle"}, 64'(done_cyc), 64'(exp_cyc));
    chk({tag, ".bsy_held"}, 64'(bsy_bad), 64'(0));
    chk({tag, ".bsy_at_done"}, 64'(bsy), 64'(0));
    chk({tag, ".nwrites"}, 64'(wd_q.size()), 64'(exp_q.size()));
    n = (wd_q.size() < exp_q.size()) ? wd_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s.chr%0d", tag, i), 64'(wd_q[i]), 64'(exp_q[i]));
      chk($sformatf("%s.adr%0d", tag, i), 64'(wa_q[i]), 64'(ASZ'(t + ASZ'(i))));
    end
    chk({tag, ".len"}, 64'(len), 64'(exp_q.size()));
    @(negedge clk);
    chk({tag, ".done_once"}, 64'({done, we, bsy}), 64'(0));
    if (poke) begin
      repeat (3) @(negedge clk);
      chk({tag, ".no_queue"}, 64'({bsy, we}), 64'(0));
    end
  endtask

  initial begin
    int wcount;
    rst = 1'b1; en = 1'b0; hex = 1'b0; vi = '0; tib = '0;
    repeat (3) @(negedge clk);
    chk("reset.outs", 64'({bsy, we, done, mo, len}), 64'(0));
    chk("reset.ma", 64'(ma), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    run("dec12345", 1'b0, 32'd12345, 17'h100, 1'b0);
    run("decm42", 1'b0, -32'sd42, 17'h200, 1'b0);
    run("hexdeadbeef", 1'b1, 32'hDEADBEEF, 17'h300, 1'b0);
    run("dec0", 1'b0, 32'd0, 17'h010, 1'b0);
    run("hex0", 1'b1, 32'd0, 17'h020, 1'b0);
    run("decmin", 1'b0, 32'h80000000, 17'h400, 1'b0);
    run("decmax", 1'b0, 32'h7FFFFFFF, 17'h500, 1'b0);
    run("hexneg", 1'b1, 32'hFFFFFFFF, 17'h1FFFC, 1'b0);
    run("decm1_wrap", 1'b0, 32'hFFFFFFFF, 17'h1FFFF, 1'b0);
    run("poke", 1'b0, 32'd987654, 17'h600, 1'b1);

    for (int k = 0; k < 10; k++) begin
      run($sformatf("rnd%0d", k), 1'($urandom), $urandom, ASZ'($urandom), 1'b0);
    end

    // Reset on the second emitted digit of a conversion.
    @(negedge clk);
    en = 1'b1; hex = 1'b0; vi = 32'd12345; tib = 17'h700;
    @(negedge clk);
    en = 1'b0;
    wcount = 0;
    for (int cyc = 0; cyc < 500 && wcount < 2; cyc++) begin
      if (we) wcount++;
      if (wcount < 2) @(negedge clk);
    end
    chk("rstmid.reached", 64'(wcount), 64'(2));
    chk("rstmid.second_chr", 64'(mo), 64'(8'h32));
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid.outs", 64'({we, bsy, done}), 64'(0));
    chk("rstmid.ma_len", 64'({ma, len}), 64'(0));
    rst = 1'b0;
    wcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (we || bsy || done) wcount++;
    end
    chk("rstmid.quiet", 64'(wcount), 64'(0));

    run("after_rst", 1'b0, 32'd12345, 17'h100, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
